qam_lock_detector: RTL and testbench

//  16-QAM hard-decision slicer and carrier-lock detector, directly downstream of the QAM PLL.

---
 rtl/qam_lock_detector.sv | 222 ++++++++++++++++++++++
 tb/tb_qam_lock_detector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qam_lock_detector.sv
// 16-QAM hard-decision slicer + windowed-error hysteresis lock detector.
// Optional QAM_LOCK_EVM_OUT_EN adds win_done/win_sum outputs.
//
// Ports:
//   clk, reset (async, active-high), clk_enable (global hold)
//   in_valid, in_i, in_q      : de-rotated signed I/Q from the PLL
//   sym_valid, sym, err_mag   : registered slicer result (latency 1)
//   locked                    : high while the FSM is in LOCKED
//   win_done, win_sum         : window-close pulse and last window sum
//                               (only with QAM_LOCK_EVM_OUT_EN)
module qam_lock_detector #(
  parameter int DATA_W     = 16,
  parameter int LEVEL      = 2048,
  parameter int WIN_LEN    = 256,
  parameter int LOCK_THR   = 65536,
  parameter int UNLOCK_THR = 131072,
  parameter int LOCK_CNT   = 4,
  parameter int MISS_CNT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  output logic                     sym_valid,
  output logic [3:0]               sym,
  output logic [DATA_W+1:0]        err_mag,
  output logic                     locked
`ifdef QAM_LOCK_EVM_OUT_EN
  ,
  output logic                     win_done,
  output logic [DATA_W+1+$clog2(WIN_LEN):0] win_sum
`endif
);

  localparam int EW    = DATA_W + 2;
  localparam int CNT_W = $clog2(WIN_LEN);
  localparam int ACC_W = EW + CNT_W;
  localparam int GC_W  = $clog2(LOCK_CNT + 1);
  localparam int MC_W  = $clog2(MISS_CNT + 1);

  localparam logic signed [EW-1:0] P_L1 = EW'(LEVEL);
  localparam logic signed [EW-1:0] P_L2 = EW'(2 * LEVEL);
  localparam logic signed [EW-1:0] P_L3 = EW'(3 * LEVEL);

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [ACC_W-1:0] P_LTHR = ACC_W'(LOCK_THR);
  localparam logic [ACC_W-1:0] P_UTHR = ACC_W'(UNLOCK_THR);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_VERIFY,
    S_LOCKED
  } state_t;

  // Returns {gray bits, |x - ideal|}; ties resolve to the higher point.
  function automatic logic [EW+1:0] slice_ax(
    input logic signed [DATA_W-1:0] x
  );
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] d;
    logic [1:0]           b;
    logic [EW-1:0]        e;
    xe = {{2{x[DATA_W-1]}}, x};
    if (xe >= P_L2) begin
      b = 2'b10;
      d = xe - P_L3;
    end else if (!xe[EW-1]) begin
      b = 2'b11;
      d = xe - P_L1;
    end else if (xe >= -P_L2) begin
      b = 2'b01;
      d = xe + P_L1;
    end else begin
      b = 2'b00;
      d = xe + P_L3;
    end
    e = d[EW-1] ? -d : d;
    return {b, e};
  endfunction

  logic [EW+1:0]    w_si;
  logic [EW+1:0]    w_sq;
  logic             w_close;
  logic [ACC_W-1:0] w_sum;
  logic             w_good;
  logic             w_bad;

  logic             r_sym_valid;
  logic [3:0]       r_sym;
  logic [EW-1:0]    r_err;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_win_cnt;
  state_t           r_state;
  logic [GC_W-1:0]  r_good_cnt;
  logic [MC_W-1:0]  r_miss_cnt;
  logic             r_locked;

  assign w_si = slice_ax(in_i);
  assign w_sq = slice_ax(in_q);

  // Stage 1: slicer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sym_valid <= 1'b0;
      r_sym       <= 4'd0;
      r_err       <= '0;
    end else if (clk_enable) begin
      r_sym_valid <= in_valid;
      if (in_valid) begin
        r_sym <= {w_si[EW+1:EW], w_sq[EW+1:EW]};
        r_err <= w_si[EW-1:0] + w_sq[EW-1:0];
      end
    end
  end

  // Stage 2: window accumulation; the closing sum includes the last sample
  assign w_sum   = r_acc + ACC_W'(r_err);
  assign w_close = clk_enable & r_sym_valid & (r_win_cnt == P_LAST);
  assign w_good  = (w_sum <= P_LTHR);
  assign w_bad   = (w_sum > P_UTHR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_win_cnt <= '0;
    end else if (clk_enable && r_sym_valid) begin
      if (r_win_cnt == P_LAST) begin
        r_acc     <= '0;
        r_win_cnt <= '0;
      end else begin
        r_acc     <= w_sum;
        r_win_cnt <= r_win_cnt + CNT_W'(1);
      end
    end
  end

  // Lock hysteresis FSM, evaluated once per closed window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_SEARCH;
      r_good_cnt <= '0;
      r_miss_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_close) begin
      unique case (r_state)
        S_SEARCH: begin
          if (w_good) begin
            r_good_cnt <= GC_W'(1);
            if (LOCK_CNT == 1) begin
              r_state    <= S_LOCKED;
              r_miss_cnt <= '0;
              r_locked   <= 1'b1;
            end else begin
              r_state <= S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          if (w_good) begin
            r_good_cnt <= r_good_cnt + GC_W'(1);
            if (r_good_cnt + GC_W'(1) == GC_W'(LOCK_CNT)) begin
              r_state    <= S_LOCKED;
              r_miss_cnt <= '0;
              r_locked   <= 1'b1;
            end
          end else begin
            r_state    <= S_SEARCH;
            r_good_cnt <= '0;
          end
        end
        S_LOCKED: begin
          if (w_bad) begin
            if (r_miss_cnt + MC_W'(1) == MC_W'(MISS_CNT)) begin
              r_state    <= S_SEARCH;
              r_good_cnt <= '0;
              r_miss_cnt <= '0;
              r_locked   <= 1'b0;
            end else begin
              r_miss_cnt <= r_miss_cnt + MC_W'(1);
            end
          end else if (w_good) begin
            r_miss_cnt <= '0;
          end
        end
        default: begin
          r_state    <= S_SEARCH;
          r_good_cnt <= '0;
          r_miss_cnt <= '0;
          r_locked   <= 1'b0;
        end
      endcase
    end
  end

  assign sym_valid = r_sym_valid;
  assign sym       = r_sym;
  assign err_mag   = r_err;
  assign locked    = r_locked;

`ifdef QAM_LOCK_EVM_OUT_EN
  logic             r_win_done;
  logic [ACC_W-1:0] r_win_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_done <= 1'b0;
      r_win_sum  <= '0;
    end else if (clk_enable) begin
      r_win_done <= w_close;
      if (w_close) begin
        r_win_sum <= w_sum;
      end
    end
  end

  assign win_done = r_win_done;
  assign win_sum  = r_win_sum;
`endif

endmodule

// File: tb/tb_qam_lock_detector.sv
// Directed bench for qam_lock_detector: slicer scoreboard,
// lock/unlock hysteresis, clock-enable freeze and mid-window reset.
module tb_qam_lock_detector;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic               in_valid;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic               sym_valid;
  logic [3:0]         sym;
  logic [17:0]        err_mag;
  logic               locked;

  int vectors = 0;
  int miscompares = 0;

  logic [21:0] exp_q[$];
  logic [21:0] last_exp;

  qam_lock_detector dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .in_valid   (in_valid),
    .in_i       (in_i),
    .in_q       (in_q),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .err_mag    (err_mag),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Nearest constellation point, scanning upward so ties go higher.
  function automatic logic [19:0] ref_axis(input int x);
    int         lv[4];
    logic [1:0] bc[4];
    int         best;
    int         db;
    int         dj;
    lv = '{-6144, -2048, 2048, 6144};
    bc = '{2'b00, 2'b01, 2'b11, 2'b10};
    best = 0;
    for (int j = 0; j < 4; j++) begin
      db = (x > lv[best]) ? x - lv[best] : lv[best] - x;
      dj = (x > lv[j]) ? x - lv[j] : lv[j] - x;
      if (dj <= db) best = j;
    end
    db = (x > lv[best]) ? x - lv[best] : lv[best] - x;
    return {bc[best], db[17:0]};
  endfunction

  function automatic logic [21:0] model(input int i, input int q);
    logic [19:0] a;
    logic [19:0] b;
    logic [17:0] s;
    a = ref_axis(i);
    b = ref_axis(q);
    s = a[17:0] + b[17:0];
    return {a[19:18], b[19:18], s};
  endfunction

  task automatic send(input int i, input int q);
    logic [21:0] e;
    @(negedge clk);
    in_valid = 1'b1;
    in_i = i[15:0];
    in_q = q[15:0];
    exp_q.push_back(model(i, q));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_exp = e;
    chk("sym_valid", {31'd0, sym_valid}, 32'd1);
    chk("sym", {28'd0, sym}, {28'd0, e[21:18]});
    chk("err_mag", {14'd0, err_mag}, {14'd0, e[17:0]});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sym_valid_idle", {31'd0, sym_valid}, 32'd0);
  endtask

  task automatic samples(input int n, input int off);
    int lv[4];
    lv = '{-6144, -2048, 2048, 6144};
    for (int k = 0; k < n; k++) begin
      send(lv[k % 4] + off, lv[(k / 4) % 4] + off);
    end
  endtask

  task automatic window(input int off, input logic exp_lock,
                        input string tag);
    samples(256, off);
    idle();
    chk(tag, {31'd0, locked}, {31'd0, exp_lock});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    chk("rst_sym", {28'd0, sym}, 32'd0);
    chk("rst_err", {14'd0, err_mag}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clk_enable = 1'b1;
    in_valid = 1'b0;
    in_i = '0;
    in_q = '0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    pulse_reset();

    // slicer points and ties
    send(2048, -6144);
    chk("t1_sym", {28'd0, sym}, 32'b1100);
    send(0, 4096);
    send(-4096, -1);
    send(32767, -32768);
    send(4095, -4097);
    idle();
    pulse_reset();

    // acquire lock with clean symbols
    window(0, 1'b0, "t3_w1");
    window(0, 1'b0, "t3_w2");
    window(0, 1'b0, "t3_w3");
    samples(256, 0);
    chk("t3_pre", {31'd0, locked}, 32'd0);
    idle();
    chk("t3_lock", {31'd0, locked}, 32'd1);

    // single bad window is forgiven; two in a row drop lock
    window(400, 1'b1, "t4_bad1");
    window(0, 1'b1, "t4_clean");
    window(400, 1'b1, "t4_bad2");
    window(400, 1'b0, "t4_unlock");

    // neutral windows never acquire
    window(192, 1'b0, "t5_n1");
    window(192, 1'b0, "t5_n2");
    window(192, 1'b0, "t5_n3");
    window(192, 1'b0, "t5_n4");
    window(192, 1'b0, "t5_n5");
    window(0, 1'b0, "t5_c1");
    window(0, 1'b0, "t5_c2");
    window(0, 1'b0, "t5_c3");
    window(0, 1'b1, "t5_c4");
    window(192, 1'b1, "t5_hold1");
    window(192, 1'b1, "t5_hold2");
    window(192, 1'b1, "t5_hold3");

    // freeze mid-window with garbage on the inputs
    samples(128, 400);
    @(negedge clk);
    clk_enable = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_i = 16'($urandom);
      in_q = 16'($urandom);
      @(posedge clk);
      #1;
      chk("frz_valid", {31'd0, sym_valid}, 32'd1);
      chk("frz_sym", {28'd0, sym}, {28'd0, last_exp[21:18]});
      chk("frz_err", {14'd0, err_mag}, {14'd0, last_exp[17:0]});
      chk("frz_lock", {31'd0, locked}, 32'd1);
      @(negedge clk);
    end
    clk_enable = 1'b1;
    in_valid = 1'b0;
    samples(128, 400);
    idle();
    chk("t6_frz_win", {31'd0, locked}, 32'd1);

    // reset mid-window discards the partial window
    samples(100, 0);
    pulse_reset();
    window(0, 1'b0, "t6_r1");
    window(0, 1'b0, "t6_r2");
    window(0, 1'b0, "t6_r3");
    window(0, 1'b1, "t6_r4");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
